// File: rtl/line_fill_buffer_pkg.sv
// Shared types and geometry for the line fill buffer; the beat/line constants
// must agree with the arbiter's arlen/arsize settings.
package line_fill_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        FILL    = 2'd2,
        DELIVER = 2'd3
    } lfb_state_t;

    // Integer log2 for power-of-two geometry values.
    function automatic int lfb_log2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    localparam int LFB_ADDR_WIDTH = 64;
    localparam int LFB_DATA_WIDTH = 64;
    localparam int LFB_BEATS      = 8;
    localparam int LFB_BOFF       = lfb_log2(LFB_DATA_WIDTH / 8);
    localparam int LFB_WIDX       = lfb_log2(LFB_BEATS);

endpackage

// File: rtl/line_fill_buffer_if.sv
// Read-port bundle between a line fill buffer (master) and the read-port arbiter (slave).
interface line_fill_buffer_if
    import line_fill_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = LFB_ADDR_WIDTH,
    parameter int DATA_WIDTH = LFB_DATA_WIDTH
) ();

    logic                  arvalid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arready;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rlast;
    logic                  rready;

    modport master (
        output arvalid,
        output araddr,
        input  arready,
        input  rvalid,
        input  rdata,
        input  rlast,
        output rready
    );

    modport slave (
        input  arvalid,
        input  araddr,
        output arready,
        output rvalid,
        output rdata,
        output rlast,
        input  rready
    );

endinterface

// File: rtl/line_fill_buffer_line_reg.sv
// Line storage: BEATS words, written at (start + offset) mod BEATS so a wrapped
// burst lands in natural word order. Cleared only by reset.
module lfb_line_reg
    import line_fill_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = LFB_DATA_WIDTH,
    parameter int BEATS      = LFB_BEATS,
    localparam int WIDX       = lfb_log2(BEATS),
    localparam int LINE_WIDTH = DATA_WIDTH * BEATS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [WIDX-1:0]       wr_start,
    input  logic [WIDX-1:0]       wr_off,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [LINE_WIDTH-1:0] line
);

    logic [WIDX-1:0] wr_idx;

    // Truncation to WIDX bits performs the modulo-BEATS wrap.
    assign wr_idx = wr_start + wr_off;

    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_word
            logic [DATA_WIDTH-1:0] word_reg;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    word_reg <= '0;
                end else if (wr_en && (wr_idx == WIDX'(gi))) begin
                    word_reg <= wr_data;
                end
            end

            assign line[gi*DATA_WIDTH +: DATA_WIDTH] = word_reg;
        end
    endgenerate

endmodule

// File: rtl/line_fill_buffer.sv
// Single-outstanding-miss line fill buffer: issues a wrapped read burst, forwards
// the critical word early, then presents the assembled line to the cache.
module line_fill_buffer
    import line_fill_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = LFB_ADDR_WIDTH,
    parameter int DATA_WIDTH = LFB_DATA_WIDTH,
    parameter int BEATS      = LFB_BEATS,
    localparam int LINE_WIDTH = DATA_WIDTH * BEATS
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  miss_valid,
    input  logic [ADDR_WIDTH-1:0] miss_addr,
    output logic                  miss_ready,

    output logic                  crit_valid,
    output logic [DATA_WIDTH-1:0] crit_data,

    output logic                  fill_valid,
    output logic [ADDR_WIDTH-1:0] fill_addr,
    output logic [LINE_WIDTH-1:0] fill_line,
    output logic                  fill_err,
    input  logic                  fill_ready,

    line_fill_buffer_if.master    rd
);

    localparam int WIDX = lfb_log2(BEATS);
    localparam int BOFF = lfb_log2(DATA_WIDTH / 8);
    localparam int CNTW = WIDX + 1;

    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(BEATS - 1);
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(BEATS);

    localparam logic [ADDR_WIDTH-1:0] BEAT_MASK = ~(ADDR_WIDTH'((64'd1 << BOFF) - 64'd1));
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~(ADDR_WIDTH'((64'd1 << (BOFF + WIDX)) - 64'd1));

    lfb_state_t state_reg, state_next;

    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [WIDX-1:0]       start_reg;
    logic [CNTW-1:0]       count_reg;
    logic                  err_reg;
    logic                  crit_valid_reg;
    logic [DATA_WIDTH-1:0] crit_data_reg;

    logic miss_take;
    logic beat_take;
    logic fill_done;
    logic arvalid_int;
    logic rready_int;
    logic line_wr_en;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        miss_ready  = 1'b0;
        arvalid_int = 1'b0;
        rready_int  = 1'b0;
        fill_valid  = 1'b0;
        miss_take   = 1'b0;
        fill_done   = 1'b0;
        beat_take   = 1'b0;

        case (state_reg)
            IDLE: begin
                miss_ready = 1'b1;
                if (miss_valid) begin
                    miss_take  = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                arvalid_int = 1'b1;
                // A beat arriving alongside the request acceptance must not be lost.
                if (rd.arready) begin
                    rready_int = 1'b1;
                    state_next = FILL;
                end
            end
            FILL: begin
                rready_int = 1'b1;
            end
            DELIVER: begin
                fill_valid = 1'b1;
                if (fill_ready) begin
                    fill_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        beat_take = rd.rvalid && rready_int;
        if (beat_take && rd.rlast) begin
            state_next = DELIVER;
        end
    end

    // ------------------------------------------------------------------
    // Miss context, beat counter, error and critical-word capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_reg       <= '0;
            start_reg      <= '0;
            count_reg      <= '0;
            err_reg        <= 1'b0;
            crit_valid_reg <= 1'b0;
            crit_data_reg  <= '0;
        end else begin
            crit_valid_reg <= 1'b0;

            if (miss_take) begin
                addr_reg  <= miss_addr;
                start_reg <= miss_addr[BOFF +: WIDX];
                count_reg <= '0;
            end

            if (beat_take) begin
                if (count_reg == '0) begin
                    crit_valid_reg <= 1'b1;
                    crit_data_reg  <= rd.rdata;
                end
                // Counter saturates at BEATS; overrun beats are flagged and dropped.
                if (count_reg != CNT_FULL) begin
                    count_reg <= count_reg + 1'b1;
                end
                if ((rd.rlast && (count_reg != CNT_LAST)) || (count_reg == CNT_FULL)) begin
                    err_reg <= 1'b1;
                end
            end

            if (fill_done) begin
                err_reg <= 1'b0;
            end
        end
    end

    assign line_wr_en = beat_take && (count_reg != CNT_FULL);

    lfb_line_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .BEATS      (BEATS)
    ) u_line_reg (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (line_wr_en),
        .wr_start (start_reg),
        .wr_off   (count_reg[WIDX-1:0]),
        .wr_data  (rd.rdata),
        .line     (fill_line)
    );

    assign rd.arvalid = arvalid_int;
    assign rd.araddr  = arvalid_int ? (addr_reg & BEAT_MASK) : '0;
    assign rd.rready  = rready_int;

    assign crit_valid = crit_valid_reg;
    assign crit_data  = crit_data_reg;
    assign fill_addr  = fill_valid ? (addr_reg & LINE_MASK) : '0;
    assign fill_err   = fill_valid && err_reg;

endmodule
